// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions: default Q16.16 widths plus conversion and clamp helpers.
// Saturation is controlled by the FXP_SATURATE_EN macro in fxp_saturate.
package fxp_pkg;

  localparam int DEF_WHOLE_W = 16;
  localparam int DEF_FRAC_W  = 16;
  localparam int DEF_W       = DEF_WHOLE_W + DEF_FRAC_W;

  function automatic logic signed [DEF_W-1:0] to_fxp(input int whole);
    to_fxp = DEF_W'(whole) <<< DEF_FRAC_W;
  endfunction

  // Integer part, floored.
  function automatic int from_fxp(input logic signed [DEF_W-1:0] value);
    from_fxp = int'(value >>> DEF_FRAC_W);
  endfunction

  // Clamp a wide signed value into the representable range of a w-bit signed word.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] value, input int w);
    logic signed [63:0] maxV;
    logic signed [63:0] minV;
    maxV = (64'sd1 <<< (w - 1)) - 64'sd1;
    minV = -(64'sd1 <<< (w - 1));
    if (value > maxV)      sat_narrow = maxV;
    else if (value < minV) sat_narrow = minV;
    else                   sat_narrow = value;
  endfunction

endpackage

// File: rtl/fxp_arith_unit_if.sv
// Operand/result bundle of fxp_arith_unit; the master side drives operands and the enable.
interface fxp_arith_unit_if #(parameter int W = 32);

  logic                calculate_en;
  logic signed [W-1:0] valueOne;
  logic signed [W-1:0] valueTwo;
  logic signed [W-1:0] addend;
  logic signed [W-1:0] difference;
  logic signed [W-1:0] product;

  modport master (
    output calculate_en, valueOne, valueTwo,
    input  addend, difference, product
  );

  modport slave (
    input  calculate_en, valueOne, valueTwo,
    output addend, difference, product
  );

endinterface

// File: rtl/fxp_saturate.sv
// Narrows a signed IN_W value to OUT_W bits: clamps with FXP_SATURATE_EN defined, wraps otherwise.
module fxp_saturate #(
  parameter int IN_W  = 33,
  parameter int OUT_W = 32
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

`ifdef FXP_SATURATE_EN
  // Representable only when every bit from OUT_W-1 upward repeats the sign.
  function automatic logic signed [OUT_W-1:0] narrow(input logic signed [IN_W-1:0] v);
    if (v[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){v[IN_W-1]}})
      narrow = v[OUT_W-1:0];
    else if (v[IN_W-1])
      narrow = {1'b1, {(OUT_W-1){1'b0}}};
    else
      narrow = {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  always_comb begin
    dout = '0;
    dout = narrow(din);
  end
`else
  logic unusedHi;

  assign unusedHi = ^din[IN_W-1:OUT_W];
  assign dout     = din[OUT_W-1:0];
`endif

endmodule

// File: rtl/fxp_arith_unit.sv
// Registered signed Qm.n add/sub/mul with one-cycle latency and throughput of one per clock.
// Overflow behaviour selected by FXP_SATURATE_EN (clamp) or its absence (wrap).
module fxp_arith_unit
  import fxp_pkg::*;
#(
  parameter int wholeWidth    = DEF_WHOLE_W,
  parameter int fractionWidth = DEF_FRAC_W
) (
  input logic             clock,
  input logic             reset,
  fxp_arith_unit_if.slave bus
);

  localparam int W = wholeWidth + fractionWidth;

  logic signed [W-1:0]   aP0;
  logic signed [W-1:0]   bP0;
  logic signed [W:0]     sumP0;
  logic signed [W:0]     diffP0;
  logic signed [2*W-1:0] aExtP0;
  logic signed [2*W-1:0] bExtP0;
  logic signed [2*W-1:0] prodFullP0;
  logic signed [2*W-1:0] prodShiftP0;
  logic signed [W-1:0]   sumNarrowP0;
  logic signed [W-1:0]   diffNarrowP0;
  logic signed [W-1:0]   prodNarrowP0;

  logic signed [W-1:0]   addendP1;
  logic signed [W-1:0]   differenceP1;
  logic signed [W-1:0]   productP1;

  // Stage 0: combinational ops at widened precision, then narrowing
  assign aP0    = bus.valueOne;
  assign bP0    = bus.valueTwo;
  assign sumP0  = {aP0[W-1], aP0} + {bP0[W-1], bP0};
  assign diffP0 = {aP0[W-1], aP0} - {bP0[W-1], bP0};

  assign aExtP0      = aP0;
  assign bExtP0      = bP0;
  assign prodFullP0  = aExtP0 * bExtP0;
  assign prodShiftP0 = prodFullP0 >>> fractionWidth;

  fxp_saturate #(.IN_W(W + 1), .OUT_W(W)) uSatAdd (
    .din  (sumP0),
    .dout (sumNarrowP0)
  );

  fxp_saturate #(.IN_W(W + 1), .OUT_W(W)) uSatSub (
    .din  (diffP0),
    .dout (diffNarrowP0)
  );

  fxp_saturate #(.IN_W(2 * W), .OUT_W(W)) uSatMul (
    .din  (prodShiftP0),
    .dout (prodNarrowP0)
  );

  // Stage 1: output register bank
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addendP1     <= '0;
      differenceP1 <= '0;
      productP1    <= '0;
    end else if (bus.calculate_en) begin
      addendP1     <= sumNarrowP0;
      differenceP1 <= diffNarrowP0;
      productP1    <= prodNarrowP0;
    end
  end

  assign bus.addend     = addendP1;
  assign bus.difference = differenceP1;
  assign bus.product    = productP1;

endmodule

// File: tb/tb_fxp_arith_unit.sv
// Self-checking bench for fxp_arith_unit (Q16.16); honours FXP_SATURATE_EN for expectations.
module tb_fxp_arith_unit;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clock;
  logic reset;
  int   checkCnt;
  int   passCnt;

  logic [31:0] expAdd;
  logic [31:0] expDiff;
  logic [31:0] expProd;

  fxp_arith_unit_if #(.W(32)) bus ();

  fxp_arith_unit #(.wholeWidth(16), .fractionWidth(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCnt++;
    if (got === want) passCnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
  endtask

  // Fit an exact integer result into 32 bits: clamp or wrap.
  function automatic logic [31:0] fitW(input longint v);
`ifdef FXP_SATURATE_EN
    if (v > MAXV) return 32'h7FFF_FFFF;
    if (v < MINV) return 32'h8000_0000;
`endif
    return v[31:0];
  endfunction

  function automatic longint sx(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return longint'(s);
  endfunction

  // Product in real-number terms: (a/2^16)*(b/2^16), floored onto the 2^-16 grid.
  function automatic logic [31:0] mulRef(input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint q;
    p = sx(a) * sx(b);
    q = p / 65536;
    if (p < 0 && (p % 65536) != 0) q = q - 1;
    return fitW(q);
  endfunction

  task automatic modelLoad(input logic [31:0] a, input logic [31:0] b);
    expAdd  = fitW(sx(a) + sx(b));
    expDiff = fitW(sx(a) - sx(b));
    expProd = mulRef(a, b);
  endtask

  task automatic checkOutputs(input string tag);
    checkEq({tag, ".add"},  bus.addend,     expAdd);
    checkEq({tag, ".diff"}, bus.difference, expDiff);
    checkEq({tag, ".prod"}, bus.product,    expProd);
  endtask

  // Present operands with enable high for one edge, then check one edge later.
  task automatic applyOp(input string tag, input logic [31:0] a, input logic [31:0] b);
    bus.valueOne     = a;
    bus.valueTwo     = b;
    bus.calculate_en = 1'b1;
    @(posedge clock);
    modelLoad(a, b);
    #1;
    checkOutputs(tag);
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($signed($urandom_range(0, 1023)) - 512);
      2:       return 32'h7FFF_0000 + 32'($urandom_range(0, 65535) * 2);
      default: return 32'($urandom_range(0, 1 << 20)) - 32'h0008_0000;
    endcase
  endfunction

  initial begin
    checkCnt = 0;
    passCnt  = 0;
    reset            = 1'b1;
    bus.calculate_en = 1'b0;
    bus.valueOne     = 32'h1234_5678;
    bus.valueTwo     = 32'h0BAD_F00D;
    repeat (2) @(posedge clock);
    #1;
    expAdd = '0; expDiff = '0; expProd = '0;
    checkOutputs("reset");
    reset = 1'b0;

    applyOp("t1", 32'h0001_8000, 32'h0002_4000);
    checkEq("t1.addConst",  bus.addend,     32'h0003_C000);
    checkEq("t1.diffConst", bus.difference, 32'hFFFF_4000);
    checkEq("t1.prodConst", bus.product,    32'h0003_6000);

    applyOp("t2", 32'hFFFE_0000, 32'h0003_0000);
    checkEq("t2.addConst",  bus.addend,     32'h0001_0000);
    checkEq("t2.diffConst", bus.difference, 32'hFFFB_0000);
    checkEq("t2.prodConst", bus.product,    32'hFFFA_0000);

    applyOp("t3", 32'h7FFF_0000, 32'h0001_0000);
`ifdef FXP_SATURATE_EN
    checkEq("t3.addConst", bus.addend, 32'h7FFF_FFFF);
`else
    checkEq("t3.addConst", bus.addend, 32'h8000_0000);
`endif

    applyOp("t4a", 32'h0100_0000, 32'h0100_0000);
`ifdef FXP_SATURATE_EN
    checkEq("t4a.prodConst", bus.product, 32'h7FFF_FFFF);
`else
    checkEq("t4a.prodConst", bus.product, 32'h0000_0000);
`endif
    applyOp("t4b", 32'hFFFF_FFFF, 32'h0000_8000);
    checkEq("t4b.prodConst", bus.product, 32'hFFFF_FFFF);

    applyOp("minNeg", 32'h8000_0000, 32'h8000_0000);
    applyOp("subMin", 32'h0000_0000, 32'h8000_0000);

    // Hold: enable low while operands churn
    applyOp("t5load", 32'h0003_0000, 32'hFFFF_8000);
    bus.calculate_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.valueOne = $urandom;
      bus.valueTwo = $urandom;
      @(posedge clock);
      #1;
      checkOutputs("t5hold");
    end

    // Randomized mix of enabled and held cycles
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic        en;
      a  = randOperand();
      b  = ($urandom_range(0, 9) == 0) ? a : randOperand();
      en = ($urandom_range(0, 3) != 0);
      bus.valueOne     = a;
      bus.valueTwo     = b;
      bus.calculate_en = en;
      @(posedge clock);
      if (en) modelLoad(a, b);
      #1;
      checkOutputs("rand");
    end

    // Async reset in the middle of enabled operation
    applyOp("t6pre", 32'h0005_0000, 32'h0002_0000);
    bus.valueOne = 32'h0007_0000;
    bus.valueTwo = 32'h0001_0000;
    #2;
    reset = 1'b1;
    #1;
    expAdd = '0; expDiff = '0; expProd = '0;
    checkOutputs("t6async");
    @(posedge clock);
    #1;
    checkOutputs("t6held");
    reset = 1'b0;
    applyOp("t6post", 32'h0001_8000, 32'h0002_4000);
    checkEq("t6post.prodConst", bus.product, 32'h0003_6000);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
